// File: rtl/cordic_pkg.sv
// Shared CORDIC types and constants: angle word, 45-degree constant, atan(2^-i) ROM.
package cordic_pkg;

  localparam int unsigned ANGLE_W      = 32;
  localparam int unsigned ATAN_ENTRIES = 32;
  localparam int unsigned ATAN_IDX_W   = 5;

  // Unsigned binary angle: 2^32 represents one full turn.
  typedef logic [ANGLE_W-1:0] angle_t;

  localparam angle_t ANGLE_45 = 32'h2000_0000;

  // Entry i = round-half-up(atan(2^-i) / (2*pi) * 2^32).
  localparam angle_t ATAN_TABLE [0:ATAN_ENTRIES-1] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  // Range-guarded lookup; any index at or beyond the limit reads as zero.
  // An unknown index fails the guard and also reads as zero.
  function automatic angle_t atan_lookup(input logic [31:0] idx,
                                         input int unsigned limit);
    angle_t res;
    res = '0;
    if ((idx < limit) && (idx < ATAN_ENTRIES)) begin
      res = ATAN_TABLE[idx[ATAN_IDX_W-1:0]];
    end
    return res;
  endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Arctangent constant ROM for the CORDIC iteration block: combinational angle
// plus a registered copy for pipelined consumers.
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_ENTRIES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       index,
  output logic [DATA_W-1:0] angle,
  output logic [DATA_W-1:0] angle_q
);

  // Zero-latency table read; independent of clk and rst.
  always_comb begin
    angle = '0;
    angle = DATA_W'(atan_lookup(index, NUM_ENTRIES));
  end

  // Registered copy of the current lookup, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle_q <= '0;
    end else begin
      angle_q <= angle;
    end
  end

endmodule

// File: tb/tb_cordic_atan_lut.sv
// Scoreboard bench for cordic_atan_lut against a real-arithmetic atan model.
module tb_cordic_atan_lut;

  localparam real PI = 3.14159265358979323846;

  logic        clk;
  logic        rst;
  logic [31:0] index;
  logic [31:0] angle;
  logic [31:0] angle_q;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q [$];

  cordic_atan_lut #(.DATA_W(32), .NUM_ENTRIES(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .index  (index),
    .angle  (angle),
    .angle_q(angle_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: round-half-up of atan(2^-i) scaled to a 2^32 full turn.
  function automatic logic [31:0] ref_angle(input logic [31:0] i);
    real    r;
    longint v;
    if (i >= 32) return 32'd0;
    r = $atan(1.0 / (2.0 ** i)) / (2.0 * PI) * 4294967296.0;
    v = longint'($floor(r + 0.5));
    return 32'(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: one registered result per edge once out of reset.
  always begin
    @(posedge clk);
    #1;
    if (!rst && exp_q.size() > 0) begin
      check("angle_q", angle_q, exp_q.pop_front());
    end
  end

  // Present a new index at the falling edge and queue the register's next value.
  task automatic drive(input logic [31:0] v);
    @(negedge clk);
    index = v;
    exp_q.push_back(ref_angle(v));
  endtask

  logic [31:0] spec_vals [0:4];
  logic [31:0] prev;

  initial begin
    spec_vals[0] = 32'h2000_0000;
    spec_vals[1] = 32'h12E4_051E;
    spec_vals[2] = 32'h09FB_385B;
    spec_vals[3] = 32'h0511_11D4;
    spec_vals[4] = 32'h028B_0D43;

    rst   = 1'b1;
    index = 32'd0;
    #2;
    check("reset angle_q", angle_q, 32'd0);

    // Combinational sweep of the first entries, in reset with no edges needed.
    for (int i = 0; i < 5; i++) begin
      index = 32'(i);
      #1;
      check($sformatf("angle[%0d]", i), angle, spec_vals[i]);
    end
    index = 32'd29;         #1; check("angle[29]", angle, 32'd1);
    index = 32'd30;         #1; check("angle[30]", angle, 32'd1);
    index = 32'd31;         #1; check("angle[31]", angle, 32'd0);
    index = 32'd32;         #1; check("angle[32]", angle, 32'd0);
    index = 32'd100;        #1; check("angle[100]", angle, 32'd0);
    index = 32'hFFFF_FFFF;  #1; check("angle[max]", angle, 32'd0);
    index = 32'h0000_0021;  #1; check("angle[33 no alias]", angle, 32'd0);
    index = 32'h8000_0001;  #1; check("angle[hi bit]", angle, 32'd0);
    check("angle_q held in reset", angle_q, 32'd0);

    // All 32 entries against real arithmetic.
    for (int i = 0; i < 32; i++) begin
      index = 32'(i);
      #1;
      check($sformatf("table[%0d]", i), angle, ref_angle(32'(i)));
    end

    // Release reset; first edge loads index 1.
    @(negedge clk);
    rst   = 1'b0;
    index = 32'd1;
    exp_q.push_back(32'h12E4_051E);
    @(posedge clk);
    #2;
    index = 32'd2;
    #1;
    check("angle_q holds between edges", angle_q, 32'h12E4_051E);
    exp_q.push_back(32'h09FB_385B);
    @(posedge clk);
    #2;
    check("angle_q after index 2", angle_q, 32'h09FB_385B);

    // Mid-stream reset clears angle_q immediately; angle keeps tracking.
    drive(32'd0);
    @(posedge clk);
    #3;
    check("angle_q pre-reset", angle_q, 32'h2000_0000);
    rst = 1'b1;
    #1;
    check("angle_q async clear", angle_q, 32'd0);
    index = 32'd5;
    #1;
    check("angle tracks in reset", angle, ref_angle(32'd5));
    @(posedge clk);
    #1;
    check("angle_q held at 0", angle_q, 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    index = 32'd7;
    exp_q.push_back(ref_angle(32'd7));

    // Sweep 0..40, registered value trails by one edge, table non-increasing.
    prev = 32'hFFFF_FFFF;
    for (int i = 0; i <= 40; i++) begin
      drive(32'(i));
      #1;
      check($sformatf("sweep angle[%0d]", i), angle, ref_angle(32'(i)));
      n_checks++;
      if (angle <= prev) n_pass++;
      else $display("FAIL monotonic[%0d]: got 0x%08h above previous 0x%08h", i, angle, prev);
      prev = angle;
    end

    // Randomised indices, half small, half full-range.
    for (int n = 0; n < 150; n++) begin
      logic [31:0] v;
      v = (n % 2 == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
      drive(v);
      #1;
      check("rand angle", angle, ref_angle(v));
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cordic_atan_lut.md
Name: cordic_atan_lut

Overview:
Arctangent constant ROM for the iterative CORDIC rotation datapath. For iteration index i it supplies atan(2^-i) as a 32-bit binary angle.
- Combinational port: the CORDIC stage uses it in the same cycle it presents i.
- Registered copy: for pipelined consumers.
Sits beside the CORDIC iteration block and is instantiated once per block.

Parameters:
- DATA_W, 32, angle word width; only 32 is supported.
- NUM_ENTRIES, 32, number of table rows; indices at or above this return 0.

Ports:
- clk  input  1  system clock; rising edge.
- rst  input  1  asynchronous reset, active-high.
- index  input  32  unsigned iteration index i.
- angle  output  32  combinational atan(2^-index), binary angle.
- angle_q  output  32  angle registered on clk.

Behaviour:
- Angle format: unsigned binary angle, 2^32 = 360 degrees (45 deg = 0x2000_0000). Entry i = round(atan(2^-i) / (2*pi) * 2^32).
- Required entries, indices 0..4:
  - 0: 0x2000_0000
  - 1: 0x12E4_051E
  - 2: 0x09FB_385B
  - 3: 0x0511_11D4
  - 4: 0x028B_0D43
- Indices 5..31 follow the same formula, with round-half-up. Examples:
  - 28: 3
  - 29: 1
  - 30: 1
  - 31: 0
- Table is monotonically non-increasing in index.
- index >= NUM_ENTRIES (any of the upper 27 bits set, or value 32..): angle = 0. No wrap-around or aliasing of low bits.
- angle is purely combinational from index, with zero latency and no dependence on clk or rst. It is valid whenever index is stable, including during reset.
- angle_q:
  - On rst high: cleared to 0 immediately (asynchronous), and held at 0 while rst is high.
  - After rst falls: on each rising clk edge, angle_q <= angle for the index present at that edge. One-cycle latency.
  - Reset asserted mid-stream: angle_q goes to 0 at once. The first post-reset edge loads the current index's value.
- No handshake, enable or state machine; the block is a pure ROM plus one output register.
- No X output for any index value. Unknown or out-of-range indices map to 0.

Decomposition:
- Shared package cordic_pkg holds:
  - ANGLE_W = 32
  - ATAN_ENTRIES = 32
  - typedef angle_t (32-bit logic)
  - constant array ATAN_TABLE[0:31] of angle_t with the values above.
  - The CORDIC iteration block uses the same package, for angle_t and the 45-degree constant.
- No sub-module. Implement the combinational mux (case or array index with range guard) and the output register in one module.

Test Plan:
1. index = 0, 1, 2, 3, 4 swept combinationally -> angle = 0x2000_0000, 0x12E4_051E, 0x09FB_385B, 0x0511_11D4, 0x028B_0D43, with no clock edge needed.
2. index = 29, 30, 31 -> angle = 1, 1, 0. index = 32, 100, 0xFFFF_FFFF -> angle = 0.
3. Release rst, drive index = 1, one rising edge -> angle_q = 0x12E4_051E. Change index to 2 between edges -> angle_q changes only at the next edge, to 0x09FB_385B.
4. Assert rst between clock edges while angle_q = 0x2000_0000 -> angle_q = 0 before the next edge. angle still tracks index during reset.
5. Sweep index 0..40, one value per cycle -> angle_q equals the previous cycle's angle every cycle, and the sequence is non-increasing.
6. Self-check all 32 entries against round(atan(2^-i)/(2*pi)*2^32) computed in the bench with real arithmetic -> exact match.
